// File: rtl/example_link_trainer.sv
// Purpose : HBWIF lane bring-up: holds the transceiver in reset, sends a training word, rotates the RX word boundary until lock, then passes user words.
// Latency : data_rx -> rx_data 1 cycle (registered aligned word); tx_data -> data_tx 1 cycle (registered).
// Backpressure: tx_ready (= linkUp) is low outside LINK; the RX side has no backpressure and rx_valid marks every LINK word.
// Optional : define EXAMPLE_LINK_TRAINER_STATS_EN to add retryCount[7:0] and lockCycles[15:0].
module example_link_trainer #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned MATCH_COUNT    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [9:0]  TRAIN_PATTERN  = 10'h0FA
) (
  input  logic        slowClk,
  input  logic        reset_n,
  input  logic        retrain,
  output logic        txrxReset,
  output logic [9:0]  data_tx,
  input  logic [9:0]  data_rx,
  input  logic [9:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [9:0]  rx_data,
  output logic        rx_valid,
  output logic        linkUp,
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
  output logic [7:0]  retryCount,
  output logic [15:0] lockCycles,
`endif
  output logic [3:0]  slip
);

  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_TRAIN = 2'd1,
    ST_LINK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [MW-1:0] match_q, match_d;
  logic [MW-1:0] match_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    hold_q, hold_d;
  logic [3:0]    slip_q, slip_d;
  logic [9:0]    prev_q;
  logic [9:0]    aligned_q, aligned_d;
  logic [9:0]    data_tx_q, data_tx_d;
  logic          txrx_q, txrx_d;
  logic          link_q, link_d;
  logic          timeout_hit;
  logic          lock_hit;
  logic [19:0]   rx_cat;

  // Two consecutive raw words; the aligned word is a 10-bit window starting at bit slip.
  assign rx_cat    = {prev_q, data_rx};
  assign aligned_d = 10'(rx_cat >> slip_q);

  // Next-state, counters and registered outputs, all derived from the next state.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    match_d     = match_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    slip_d      = slip_q;
    match_inc   = match_q + MW'(1);
    timeout_hit = 1'b0;
    lock_hit    = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d = ST_TRAIN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_TRAIN: begin
        // Saturating so a stuck timer can never wrap back into range.
        if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + TW'(1);
        end
        if (hold_q != 2'd0) begin
          // The aligned register still holds a word taken at the old offset.
          hold_d = hold_q - 2'd1;
        end else if (aligned_q == TRAIN_PATTERN) begin
          match_d  = match_inc;
          lock_hit = (match_inc == MW'(MATCH_COUNT));
        end else begin
          match_d = '0;
          slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
          hold_d  = 2'd2;
        end
        timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
        if (timeout_hit) begin
          state_d = ST_RESET;
        end else if (lock_hit) begin
          state_d = ST_LINK;
        end
      end
      ST_LINK: begin
        // Alignment frozen; only retrain leaves this state.
      end
      default: state_d = ST_RESET;
    endcase

    // Retrain overrides any lock or timeout decided above.
    if (retrain) begin
      state_d = ST_RESET;
    end

    // Entering RESET (or restarting it) starts a fresh attempt.
    if (retrain || (state_q != ST_RESET && state_d == ST_RESET)) begin
      rst_cnt_d = '0;
      match_d   = '0;
      timer_d   = '0;
      hold_d    = 2'd0;
      slip_d    = 4'd0;
    end

    txrx_d = (state_d == ST_RESET);
    link_d = (state_d == ST_LINK);
    case (state_d)
      ST_TRAIN: data_tx_d = TRAIN_PATTERN;
      ST_LINK:  data_tx_d = tx_valid ? tx_data : TRAIN_PATTERN;
      default:  data_tx_d = 10'd0;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge slowClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      match_q   <= '0;
      timer_q   <= '0;
      hold_q    <= 2'd0;
      slip_q    <= 4'd0;
      prev_q    <= 10'd0;
      aligned_q <= 10'd0;
      data_tx_q <= 10'd0;
      txrx_q    <= 1'b1;
      link_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      match_q   <= match_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      slip_q    <= slip_d;
      prev_q    <= data_rx;
      aligned_q <= aligned_d;
      data_tx_q <= data_tx_d;
      txrx_q    <= txrx_d;
      link_q    <= link_d;
    end
  end

  assign txrxReset = txrx_q;
  assign data_tx   = data_tx_q;
  assign rx_data   = aligned_q;
  assign rx_valid  = link_q;
  assign linkUp    = link_q;
  assign tx_ready  = link_q;
  assign slip      = slip_q;

`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
  logic [7:0]  retry_q, retry_d;
  logic [15:0] lock_cycles_q, lock_cycles_d;

  // Count timeouts that actually restart the lane; latch the timer on lock.
  always_comb begin
    retry_d       = retry_q;
    lock_cycles_d = lock_cycles_q;
    if (timeout_hit && !retrain && retry_q != 8'hFF) begin
      retry_d = retry_q + 8'd1;
    end
    if (state_q != ST_LINK && state_d == ST_LINK) begin
      lock_cycles_d = 16'(timer_q);
    end
  end

  // Statistics registers, cleared only by reset_n.
  always_ff @(posedge slowClk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q       <= 8'd0;
      lock_cycles_q <= 16'd0;
    end else begin
      retry_q       <= retry_d;
      lock_cycles_q <= lock_cycles_d;
    end
  end

  assign retryCount = retry_q;
  assign lockCycles = lock_cycles_q;
`endif

endmodule

// File: tb/tb_example_link_trainer.sv
`timescale 1ns/1ps
// Bench for example_link_trainer: serial loopback with a 3-bit boundary offset,
// scoreboard on the aligned RX stream, reference timing derived from the
// training rules (one slip per 3 cycles, lock after MATCH consecutive matches).
module tb_example_link_trainer;
  localparam logic [9:0] PAT       = 10'h0FA;
  localparam int         RESET_CYC = 16;
  localparam int         MATCH     = 8;
  localparam int         TIMEOUT   = 1024;
  localparam int         M_LOCK    = 0;
  localparam int         M_RETRAIN = 1;
  localparam int         M_STUCK   = 2;
  localparam int         M_ABORT   = 3;
  // With data stuck, slip has stepped 6 times after 1 + 3*5 TRAIN cycles.
  localparam int         ABORT_T   = 1 + 3 * 5;

  logic       slowClk  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       retrain  = 1'b0;
  logic       tx_valid = 1'b0;
  logic [9:0] tx_data  = 10'd0;
  logic       txrxReset, tx_ready, rx_valid, linkUp;
  logic [9:0] data_tx, data_rx, rx_data;
  logic [3:0] slip;
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
  logic [7:0]  retryCount;
  logic [15:0] lockCycles;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         s_lock;
  int         lock_t;
  logic       stuck  = 1'b0;
  logic [9:0] txd_prev = 10'd0;

  typedef struct {
    logic [9:0] d;
    int         due;
  } exp_t;
  exp_t sbq[$];

  example_link_trainer dut (
    .slowClk   (slowClk),
    .reset_n   (reset_n),
    .retrain   (retrain),
    .txrxReset (txrxReset),
    .data_tx   (data_tx),
    .data_rx   (data_rx),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .linkUp    (linkUp),
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
    .retryCount(retryCount),
    .lockCycles(lockCycles),
`endif
    .slip      (slip)
  );

  always #5 slowClk = ~slowClk;

  // Loopback: the receiver's word boundary sits 3 bits late in the serial stream.
  always @(posedge slowClk) begin
    cyc      <= cyc + 1;
    txd_prev <= data_tx;
  end
  assign data_rx = stuck ? 10'h000 : {txd_prev[6:0], data_tx[9:7]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offset that undoes the loopback rotation of a steady training stream.
  function automatic int find_lock_slip();
    logic [9:0]  p;
    logic [9:0]  rx;
    logic [19:0] cat;
    p   = PAT;
    rx  = {p[6:0], p[9:7]};
    cat = {rx, rx};
    for (int s = 0; s < 10; s++) begin
      if (10'(cat >> s) == p) return s;
    end
    return -1;
  endfunction

  // Slip steps taken after t TRAIN cycles: first compare at t=1, then every 3 cycles.
  function automatic int steps_at(input int t);
    return (t >= 1) ? ((t - 1) / 3 + 1) : 0;
  endfunction

  // Monitor: pop expectations as they fall due and compare the aligned RX word.
  always @(negedge slowClk) begin
    if (sbq.size() > 0) begin
      if (sbq[0].due == cyc) begin
        chk("sb_rx_valid", 32'(rx_valid), 32'(1));
        chk("sb_rx_data", 32'(rx_data), 32'(sbq[0].d));
        sbq.delete(0);
      end
    end
  end

  // Called at the negedge of the first RESET cycle; runs one bring-up attempt.
  task automatic bringup(input int mode);
    int t;
    int st;
    int exp_slip;
    bit done;
    for (int i = 0; i < RESET_CYC; i++) begin
      chk("reset_txrx", 32'(txrxReset), 32'(1));
      chk("reset_data_tx", 32'(data_tx), 32'(0));
      chk("reset_linkup", 32'(linkUp), 32'(0));
      @(negedge slowClk);
    end
    chk("train_entry_txrx", 32'(txrxReset), 32'(0));
    t = 0;
    done = 1'b0;
    while (!done) begin
      st = steps_at(t);
      if (mode == M_STUCK || mode == M_ABORT) exp_slip = st % 10;
      else exp_slip = (st < s_lock) ? st : s_lock;
      if (mode == M_LOCK && t == lock_t) begin
        chk("lock_linkup", 32'(linkUp), 32'(1));
        chk("lock_tx_ready", 32'(tx_ready), 32'(1));
        chk("lock_rx_valid", 32'(rx_valid), 32'(1));
        chk("lock_slip", 32'(slip), 32'(s_lock));
        chk("lock_txrx", 32'(txrxReset), 32'(0));
        done = 1'b1;
      end else begin
        chk("train_slip", 32'(slip), 32'(exp_slip));
        chk("train_linkup", 32'(linkUp), 32'(0));
        chk("train_rx_valid", 32'(rx_valid), 32'(0));
        chk("train_data_tx", 32'(data_tx), 32'(PAT));
        chk("train_txrx", 32'(txrxReset), 32'(0));
        if (mode == M_RETRAIN && t == lock_t - 1) begin
          retrain = 1'b1;
          @(negedge slowClk);
          retrain = 1'b0;
          chk("retrain_at_lock_linkup", 32'(linkUp), 32'(0));
          chk("retrain_at_lock_txrx", 32'(txrxReset), 32'(1));
          done = 1'b1;
        end else if (mode == M_ABORT && t == ABORT_T) begin
          reset_n = 1'b0;
          #1;
          chk("abort_slip", 32'(slip), 32'(0));
          chk("abort_data_tx", 32'(data_tx), 32'(0));
          chk("abort_txrx", 32'(txrxReset), 32'(1));
          chk("abort_linkup", 32'(linkUp), 32'(0));
          @(negedge slowClk);
          reset_n = 1'b1;
          done = 1'b1;
        end else if (mode == M_STUCK && t == TIMEOUT - 1) begin
          @(negedge slowClk);
          chk("timeout_txrx", 32'(txrxReset), 32'(1));
          chk("timeout_slip", 32'(slip), 32'(0));
          done = 1'b1;
        end else begin
          t++;
          @(negedge slowClk);
        end
      end
    end
  endtask

  // Linked traffic: random words with random valid, then an idle tail that drains the scoreboard.
  task automatic traffic(input int n, input bit directed);
    logic [9:0] exp_next;
    logic [9:0] w;
    bit         v;
    exp_next = PAT;
    for (int i = 0; i < n; i++) begin
      chk("link_linkup", 32'(linkUp), 32'(1));
      chk("link_tx_ready", 32'(tx_ready), 32'(1));
      chk("link_data_tx", 32'(data_tx), 32'(exp_next));
      w = 10'($urandom_range(1023, 0));
      v = 1'($urandom_range(1, 0));
      if (directed && i == 0) begin v = 1'b1; w = 10'h155; end
      if (directed && i == 1) begin v = 1'b1; w = 10'h2AA; end
      if (i >= n - 4) v = 1'b0;
      tx_valid = v;
      tx_data  = w;
      exp_next = v ? w : PAT;
      sbq.push_back('{d: exp_next, due: cyc + 3});
      @(negedge slowClk);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_data_tx", 32'(data_tx), 32'(exp_next));
      chk("idle_rx_valid", 32'(rx_valid), 32'(1));
      exp_next = PAT;
      @(negedge slowClk);
    end
  endtask

  initial begin
    s_lock = find_lock_slip();
    lock_t = 1 + 3 * s_lock + MATCH - 1;
    repeat (2) @(negedge slowClk);
    chk("por_txrx", 32'(txrxReset), 32'(1));
    chk("por_data_tx", 32'(data_tx), 32'(0));
    chk("por_rx_data", 32'(rx_data), 32'(0));
    chk("por_rx_valid", 32'(rx_valid), 32'(0));
    chk("por_linkup", 32'(linkUp), 32'(0));
    chk("por_tx_ready", 32'(tx_ready), 32'(0));
    chk("por_slip", 32'(slip), 32'(0));
    reset_n = 1'b1;
    bringup(M_LOCK);
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
    chk("stats_lock_cycles", 32'(lockCycles), 32'(lock_t - 1));
    chk("stats_retry0", 32'(retryCount), 32'(0));
`endif
    traffic(24, 1'b1);

    retrain = 1'b1;
    @(negedge slowClk);
    retrain = 1'b0;
    chk("retrain_linkup", 32'(linkUp), 32'(0));
    chk("retrain_tx_ready", 32'(tx_ready), 32'(0));
    chk("retrain_rx_valid", 32'(rx_valid), 32'(0));
    bringup(M_RETRAIN);
    bringup(M_LOCK);
    traffic(8, 1'b0);

    stuck   = 1'b1;
    retrain = 1'b1;
    @(negedge slowClk);
    retrain = 1'b0;
    bringup(M_STUCK);
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
    chk("stats_retry1", 32'(retryCount), 32'(1));
`endif
    bringup(M_STUCK);
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
    chk("stats_retry2", 32'(retryCount), 32'(2));
`endif
    bringup(M_ABORT);
`ifdef EXAMPLE_LINK_TRAINER_STATS_EN
    chk("stats_retry_cleared", 32'(retryCount), 32'(0));
`endif
    stuck = 1'b0;
    bringup(M_LOCK);
    traffic(12, 1'b0);
    chk("sb_drained", 32'(sbq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
